// File: rtl/usart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// usart_rx_deserializer
//
// Receive engine for the USART single-wire link. Oversamples the asynchronous
// `sig` line, recovers one frame (start bit, DATA_LENGTH data bits LSB first,
// parity bit, stop bit) and presents the word on a valid/ready handshake.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   sig            serial line, idles high, asynchronous to clk
//   data           received word (stable while valid=1)
//   valid          data/parity_error hold a received frame
//   ready          consumer accepts data when valid & ready
//   parity_error   parity mismatch on the held frame, qualified by valid
//   framing_error  1-cycle pulse: stop bit sampled low, frame discarded
//   overrun        1-cycle pulse: good frame dropped, previous not consumed
// -----------------------------------------------------------------------------
module usart_rx_deserializer #(
  parameter int DATA_LENGTH  = 48,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sig,
  output logic [DATA_LENGTH-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   parity_error,
  output logic                   framing_error,
  output logic                   overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_LENGTH + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_LENGTH - 1);
  localparam logic          ODD      = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic sig_meta, sig_s, sig_s_d;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_LENGTH-1:0] word;
  logic parity_bit;

  // Control strobes produced by the next-state logic.
  logic cnt_clr, idx_clr, shift_en, par_en, stop_en;
  logic fall, perr;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  // Resets to 1 so that leaving reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_meta <= 1'b1;
      sig_s    <= 1'b1;
      sig_s_d  <= 1'b1;
    end else begin
      sig_meta <= sig;
      sig_s    <= sig_meta;
      sig_s_d  <= sig_s;
    end
  end

  assign fall = sig_s_d & ~sig_s;
  assign perr = (^word) ^ parity_bit ^ ODD;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe logic. START waits half a bit so every later sample
  // lands mid-bit; each subsequent sample is a full bit period apart.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_n  = state;
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          if (sig_s) begin
            state_n = IDLE;              // glitch, not a real start bit
          end else begin
            state_n = DATA;
            idx_clr = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) state_n = PARITY;
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_clr = 1'b1;
          stop_en = 1'b1;
          state_n = IDLE;                // ready for a start edge right after
        end
      end
      default: begin
        state_n = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cycle counter and bit index: cleared explicitly, never free-running.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + BW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Assembly shift register and captured parity bit.
  // ---------------------------------------------------------------------------
  // NOTE: no reset here on purpose: all DATA_LENGTH bits and the parity bit are
  // rewritten before the stop sample reads them, so a reset would buy nothing.
  always_ff @(posedge clk) begin
    if (shift_en) word <= {sig_s, word[DATA_LENGTH-1:1]};   // LSB arrives first
    if (par_en)   parity_bit <= sig_s;
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake. A load in the same cycle as a consume keeps
  // valid high with the new word; otherwise valid & ready clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data          <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      if (stop_en) begin
        if (!sig_s) begin
          framing_error <= 1'b1;
        end else if (!valid || ready) begin
          data         <= word;
          parity_error <= perr;
          valid        <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_usart_rx_deserializer
//
// Self-checking bench for usart_rx_deserializer (DATA_LENGTH=48,
// CLKS_PER_BIT=4, even parity). Frames are built bit by bit from the frame
// format; a negedge monitor logs every handshake and counts flag pulses, and
// each scenario compares that log with what the frame rules predict.
// -----------------------------------------------------------------------------
module tb_usart_rx_deserializer;

  localparam int DL  = 48;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sig = 1'b1;
  logic [DL-1:0] data;
  logic          valid;
  logic          ready = 1'b0;
  logic          parity_error;
  logic          framing_error;
  logic          overrun;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state (written only by the monitor process).
  int            fe_cnt = 0;
  int            ovr_cnt = 0;
  int            vcyc = 0;
  int            got_n = 0;
  logic [DL-1:0] got_word [0:255];
  logic          got_perr [0:255];

  usart_rx_deserializer #(
    .DATA_LENGTH (DL),
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sig          (sig),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (framing_error) fe_cnt++;
    if (overrun) ovr_cnt++;
    if (valid) vcyc++;
    if (valid && ready && got_n < 256) begin
      got_word[got_n] = data;
      got_perr[got_n] = parity_error;
      got_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic b);
    sig = b;
    repeat (CPB) tick();
  endtask

  // Start bit, data LSB first, parity (even, optionally inverted), stop bit.
  task automatic send_frame(input logic [DL-1:0] w, input logic flip, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DL; i++) drive_bit(w[i]);
    drive_bit((^w) ^ flip);
    drive_bit(stop_bit);
    sig = 1'b1;
  endtask

  task automatic test_reset();
    sig = 1'b1;
    reset_n = 1'b0;
    idle(3);
    vectors++;
    if ({data, valid, parity_error, framing_error, overrun} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got data=%h valid=%b perr=%b fe=%b ovr=%b exp all 0",
               data, valid, parity_error, framing_error, overrun);
    end
    reset_n = 1'b1;
    idle(4);
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_valid got=%b exp=0", valid);
    end
    vectors++;
    if (data !== '0) begin
      miscompares++;
      $display("FAIL reset_release_data got=%h exp=0", data);
    end
  endtask

  task automatic test_basic();
    int base = got_n;
    int vbase;
    int fbase = fe_cnt;
    int waited = 0;
    ready = 1'b1;
    send_frame(48'hA5A5_0F0F_1234, 1'b0, 1'b1);
    while (!valid && waited < 4 * CPB) begin
      tick();
      waited++;
    end
    vectors++;
    if (!(valid === 1'b1 && waited >= 1 && waited <= CPB)) begin
      miscompares++;
      $display("FAIL basic_latency got valid=%b after %0d clks exp valid=1 within 1..%0d",
               valid, waited, CPB);
    end
    vbase = vcyc;
    idle(8);
    vectors++;
    if (vcyc - vbase !== 1) begin
      miscompares++;
      $display("FAIL basic_valid_width got=%0d cycles exp=1", vcyc - vbase);
    end
    vectors++;
    if (got_n - base !== 1 || got_word[base] !== 48'hA5A5_0F0F_1234 || got_perr[base] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_word got n=%0d data=%h perr=%b exp n=1 data=a5a50f0f1234 perr=0",
               got_n - base, got_word[base], got_perr[base]);
    end
    vectors++;
    if (fe_cnt - fbase !== 0) begin
      miscompares++;
      $display("FAIL basic_framing got=%0d exp=0", fe_cnt - fbase);
    end
  endtask

  task automatic test_parity_error();
    int base = got_n;
    int fbase = fe_cnt;
    ready = 1'b1;
    send_frame(48'hA5A5_0F0F_1234, 1'b1, 1'b1);
    idle(8);
    vectors++;
    if (got_n - base !== 1 || got_word[base] !== 48'hA5A5_0F0F_1234 || got_perr[base] !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_word got n=%0d data=%h perr=%b exp n=1 data=a5a50f0f1234 perr=1",
               got_n - base, got_word[base], got_perr[base]);
    end
    vectors++;
    if (fe_cnt - fbase !== 0) begin
      miscompares++;
      $display("FAIL parity_framing got=%0d exp=0", fe_cnt - fbase);
    end
  endtask

  task automatic test_framing();
    int fbase = fe_cnt;
    int vbase = vcyc;
    ready = 1'b1;
    send_frame(48'h0123_4567_89AB, 1'b0, 1'b0);
    idle(8);
    vectors++;
    if (fe_cnt - fbase !== 1) begin
      miscompares++;
      $display("FAIL framing_pulse got=%0d cycles exp=1", fe_cnt - fbase);
    end
    vectors++;
    if (vcyc - vbase !== 0) begin
      miscompares++;
      $display("FAIL framing_valid got=%0d valid cycles exp=0", vcyc - vbase);
    end
    vectors++;
    if (data !== 48'hA5A5_0F0F_1234) begin
      miscompares++;
      $display("FAIL framing_data_kept got=%h exp=a5a50f0f1234", data);
    end
  endtask

  task automatic test_back_to_back();
    int base = got_n;
    int obase = ovr_cnt;
    ready = 1'b0;
    send_frame(48'h1, 1'b0, 1'b1);
    send_frame(48'h2, 1'b0, 1'b1);
    idle(8);
    vectors++;
    if (valid !== 1'b1 || data !== 48'h1) begin
      miscompares++;
      $display("FAIL b2b_held got valid=%b data=%h exp valid=1 data=1", valid, data);
    end
    vectors++;
    if (ovr_cnt - obase !== 1) begin
      miscompares++;
      $display("FAIL b2b_overrun got=%0d exp=1", ovr_cnt - obase);
    end
    ready = 1'b1;
    tick();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_valid_drop got=%b exp=0", valid);
    end
    vectors++;
    if (got_n - base !== 1 || got_word[base] !== 48'h1) begin
      miscompares++;
      $display("FAIL b2b_consumed got n=%0d data=%h exp n=1 data=1", got_n - base, got_word[base]);
    end
  endtask

  task automatic test_glitch();
    int base = got_n;
    int fbase = fe_cnt;
    int obase = ovr_cnt;
    ready = 1'b1;
    sig = 1'b0;
    tick();
    sig = 1'b1;
    idle(12);
    vectors++;
    if (fe_cnt - fbase !== 0 || ovr_cnt - obase !== 0 || valid !== 1'b0 || got_n - base !== 0) begin
      miscompares++;
      $display("FAIL glitch_quiet got fe=%0d ovr=%0d valid=%b words=%0d exp all 0",
               fe_cnt - fbase, ovr_cnt - obase, valid, got_n - base);
    end
    send_frame(48'h5A5A_C3C3_7E81, 1'b0, 1'b1);
    idle(8);
    vectors++;
    if (got_n - base !== 1 || got_word[base] !== 48'h5A5A_C3C3_7E81 || got_perr[base] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_followup got n=%0d data=%h perr=%b exp n=1 data=5a5ac3c37e81 perr=0",
               got_n - base, got_word[base], got_perr[base]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    ready = 1'b1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset_n = 1'b0;
    sig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({data, valid, parity_error, framing_error, overrun} !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_outputs cycle %0d got data=%h valid=%b perr=%b fe=%b ovr=%b exp all 0",
                 i, data, valid, parity_error, framing_error, overrun);
      end
    end
    reset_n = 1'b1;
    idle(8);
    base = got_n;
    send_frame(48'hFFFF_FFFF_FFFF, 1'b0, 1'b1);
    idle(8);
    vectors++;
    if (got_n - base !== 1 || got_word[base] !== 48'hFFFF_FFFF_FFFF || got_perr[base] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_frame got n=%0d data=%h perr=%b exp n=1 data=ffffffffffff perr=0",
               got_n - base, got_word[base], got_perr[base]);
    end
  endtask

  // Random frames against a handshake model: a held word is consumed as soon
  // as ready is raised; a good frame loads when nothing is held or ready is
  // high, otherwise it is an overrun; a low stop bit is a framing error.
  task automatic test_random();
    logic [DL-1:0] exp_word [$];
    logic          exp_perr [$];
    logic [DL-1:0] held_word = '0;
    logic          held_perr = 1'b0;
    logic          held_valid = 1'b0;
    int            exp_fe = 0;
    int            exp_ovr = 0;
    int            base = got_n;
    int            fbase = fe_cnt;
    int            obase = ovr_cnt;
    int            n;

    for (int f = 0; f < 20; f++) begin
      logic [DL-1:0] w;
      logic          flip, stop_bit, r;
      w        = DL'({$urandom(), $urandom()});
      flip     = ($urandom_range(0, 3) == 0);
      stop_bit = ($urandom_range(0, 6) != 0);
      r        = 1'($urandom_range(0, 1));

      ready = r;
      if (r && held_valid) begin
        exp_word.push_back(held_word);
        exp_perr.push_back(held_perr);
        held_valid = 1'b0;
      end
      if (!stop_bit) begin
        exp_fe++;
      end else if (held_valid) begin
        exp_ovr++;
      end else if (r) begin
        exp_word.push_back(w);
        exp_perr.push_back(flip);
      end else begin
        held_word  = w;
        held_perr  = flip;
        held_valid = 1'b1;
      end
      send_frame(w, flip, stop_bit);
      idle(8);
    end
    ready = 1'b1;
    if (held_valid) begin
      exp_word.push_back(held_word);
      exp_perr.push_back(held_perr);
    end
    idle(4);

    n = exp_word.size();
    vectors++;
    if (got_n - base !== n) begin
      miscompares++;
      $display("FAIL random_count got=%0d exp=%0d", got_n - base, n);
    end
    for (int i = 0; i < n && base + i < got_n; i++) begin
      vectors++;
      if (got_word[base+i] !== exp_word[i] || got_perr[base+i] !== exp_perr[i]) begin
        miscompares++;
        $display("FAIL random_word[%0d] got data=%h perr=%b exp data=%h perr=%b",
                 i, got_word[base+i], got_perr[base+i], exp_word[i], exp_perr[i]);
      end
    end
    vectors++;
    if (fe_cnt - fbase !== exp_fe) begin
      miscompares++;
      $display("FAIL random_framing got=%0d exp=%0d", fe_cnt - fbase, exp_fe);
    end
    vectors++;
    if (ovr_cnt - obase !== exp_ovr) begin
      miscompares++;
      $display("FAIL random_overrun got=%0d exp=%0d", ovr_cnt - obase, exp_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_framing();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
